// File: rtl/feature_mem_loader.sv
// -----------------------------------------------------------------------------
// feature_mem_loader
//
// Write-side sequencer for the scratchpad feature memory. It accepts a
// valid/ready stream of DATA_BUS_WIDTH-bit words and turns each accepted word
// into one registered write on the feature memory write port.
//
// Two fill modes are supported:
//   - full mode   : cfg_groups x cfg_lines words, written in group-major order
//                   (all lines of group 0, then all lines of group 1, ...).
//   - single mode : one word per group, always written to line cfg_line_sel.
//                   This is the line-buffer shift case.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   start           one-cycle load request, only looked at while idle
//   cfg_groups      groups to fill (1..Tn)
//   cfg_lines       lines per group in full mode (1..KERNEL_SIZE)
//   cfg_single      1 selects single-line mode
//   cfg_line_sel    target line in single-line mode (0..KERNEL_SIZE-1)
//   s_valid/s_data  input stream word
//   s_ready         high while loading; depends on state only
//   wr_en           memory write strobe (one cycle after the handshake)
//   wr_mem_group    target group of the write
//   wr_mem_line     target line of the write
//   wr_data         data word of the write
//   busy            high while a load is in progress (LOAD and DONE)
//   done            one-cycle pulse in the cycle the last write is issued
//   cfg_err         one-cycle pulse when a start is rejected
// -----------------------------------------------------------------------------
module feature_mem_loader #(
   parameter int Tn             = 4,
   parameter int KERNEL_SIZE    = 3,
   parameter int DATA_BUS_WIDTH = 128
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic [3:0]                cfg_groups,
   input  logic [3:0]                cfg_lines,
   input  logic                      cfg_single,
   input  logic [3:0]                cfg_line_sel,
   input  logic                      s_valid,
   input  logic [DATA_BUS_WIDTH-1:0] s_data,
   output logic                      s_ready,
   output logic                      wr_en,
   output logic [3:0]                wr_mem_group,
   output logic [3:0]                wr_mem_line,
   output logic [DATA_BUS_WIDTH-1:0] wr_data,
   output logic                      busy,
   output logic                      done,
   output logic                      cfg_err
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Limits widened to 5 bits so that Tn or KERNEL_SIZE equal to 16 still
   // compare correctly against the 4-bit configuration fields.
   localparam logic [4:0] TN_MAX = 5'(Tn);
   localparam logic [4:0] K_MAX  = 5'(KERNEL_SIZE);

   state_t                    state_q, state_d;
   logic [3:0]                grp_cnt_q, grp_cnt_d;
   logic [3:0]                line_cnt_q, line_cnt_d;
   logic [3:0]                cfg_groups_q, cfg_groups_d;
   logic [3:0]                cfg_lines_q, cfg_lines_d;
   logic                      cfg_single_q, cfg_single_d;
   logic [3:0]                cfg_line_sel_q, cfg_line_sel_d;
   logic                      wr_en_q, wr_en_d;
   logic [3:0]                wr_group_q, wr_group_d;
   logic [3:0]                wr_line_q, wr_line_d;
   logic [DATA_BUS_WIDTH-1:0] wr_data_q, wr_data_d;
   logic                      cfg_err_q, cfg_err_d;

   logic                      cfg_bad;
   logic                      last_grp;
   logic                      last_line;

   // Configuration check on the live inputs; only meaningful when start is
   // seen in IDLE.
   always_comb begin
      cfg_bad = 1'b0;
      if ((cfg_groups == 4'd0) || ({1'b0, cfg_groups} > TN_MAX)) begin
         cfg_bad = 1'b1;
      end
      if (cfg_single) begin
         if ({1'b0, cfg_line_sel} >= K_MAX) begin
            cfg_bad = 1'b1;
         end
      end else begin
         if ((cfg_lines == 4'd0) || ({1'b0, cfg_lines} > K_MAX)) begin
            cfg_bad = 1'b1;
         end
      end
   end

   assign last_grp  = (grp_cnt_q == (cfg_groups_q - 4'd1));
   assign last_line = (line_cnt_q == (cfg_lines_q - 4'd1));

   always_comb begin
      state_d        = state_q;
      grp_cnt_d      = grp_cnt_q;
      line_cnt_d     = line_cnt_q;
      cfg_groups_d   = cfg_groups_q;
      cfg_lines_d    = cfg_lines_q;
      cfg_single_d   = cfg_single_q;
      cfg_line_sel_d = cfg_line_sel_q;
      // Write port returns to all-zero in every cycle without a handshake.
      wr_en_d        = 1'b0;
      wr_group_d     = 4'd0;
      wr_line_d      = 4'd0;
      wr_data_d      = '0;
      cfg_err_d      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (cfg_bad) begin
                  cfg_err_d = 1'b1;
               end else begin
                  cfg_groups_d   = cfg_groups;
                  cfg_lines_d    = cfg_lines;
                  cfg_single_d   = cfg_single;
                  cfg_line_sel_d = cfg_line_sel;
                  grp_cnt_d      = 4'd0;
                  line_cnt_d     = 4'd0;
                  state_d        = ST_LOAD;
               end
            end
         end

         ST_LOAD: begin
            // s_ready is high for the whole of LOAD, so s_valid alone
            // marks a handshake here.
            if (s_valid) begin
               wr_en_d    = 1'b1;
               wr_group_d = grp_cnt_q;
               wr_line_d  = cfg_single_q ? cfg_line_sel_q : line_cnt_q;
               wr_data_d  = s_data;

               if (last_grp && (cfg_single_q || last_line)) begin
                  state_d = ST_DONE;
               end

               if (cfg_single_q) begin
                  grp_cnt_d = grp_cnt_q + 4'd1;
               end else if (last_line) begin
                  line_cnt_d = 4'd0;
                  grp_cnt_d  = grp_cnt_q + 4'd1;
               end else begin
                  line_cnt_d = line_cnt_q + 4'd1;
               end
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         grp_cnt_q      <= 4'd0;
         line_cnt_q     <= 4'd0;
         cfg_groups_q   <= 4'd0;
         cfg_lines_q    <= 4'd0;
         cfg_single_q   <= 1'b0;
         cfg_line_sel_q <= 4'd0;
         wr_en_q        <= 1'b0;
         wr_group_q     <= 4'd0;
         wr_line_q      <= 4'd0;
         wr_data_q      <= '0;
         cfg_err_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         grp_cnt_q      <= grp_cnt_d;
         line_cnt_q     <= line_cnt_d;
         cfg_groups_q   <= cfg_groups_d;
         cfg_lines_q    <= cfg_lines_d;
         cfg_single_q   <= cfg_single_d;
         cfg_line_sel_q <= cfg_line_sel_d;
         wr_en_q        <= wr_en_d;
         wr_group_q     <= wr_group_d;
         wr_line_q      <= wr_line_d;
         wr_data_q      <= wr_data_d;
         cfg_err_q      <= cfg_err_d;
      end
   end

   assign s_ready      = (state_q == ST_LOAD);
   assign busy         = (state_q != ST_IDLE);
   assign done         = (state_q == ST_DONE);
   assign cfg_err      = cfg_err_q;
   assign wr_en        = wr_en_q;
   assign wr_mem_group = wr_group_q;
   assign wr_mem_line  = wr_line_q;
   assign wr_data      = wr_data_q;

endmodule

// File: doc/feature_mem_loader.md
# feature_mem_loader

Write-side sequencer for the scratchpad feature memory. Accepts a valid/ready stream of DATA_BUS_WIDTH-bit feature words and converts it into the memory's write-port protocol: wr_en, wr_mem_group, wr_mem_line and the data word. It fills a configurable number of groups × lines in group-major order, or one selected line per group in single-line (line-buffer shift) mode. It sits between the input DMA stream and the feature memory write port.

## Interface
- Tn, 4, number of memory groups (≤ 16)
- KERNEL_SIZE, 3, lines per group (≤ 16)
- DATA_BUS_WIDTH, 128, width of one stream word / one memory line write
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle request to begin a load; sampled only in IDLE
- cfg_groups  in  4  number of groups to fill, legal 1..Tn
- cfg_lines  in  4  lines per group, legal 1..KERNEL_SIZE (full mode)
- cfg_single  in  1  1 = single-line mode: one word per group, written to line cfg_line_sel
- cfg_line_sel  in  4  target line in single-line mode, legal 0..KERNEL_SIZE-1
- s_valid  in  1  stream word valid
- s_data  in  DATA_BUS_WIDTH  stream word
- s_ready  out  1  loader accepts word
- wr_en  out  1  memory write strobe
- wr_mem_group  out  4  target group
- wr_mem_line  out  4  target line
- wr_data  out  DATA_BUS_WIDTH  word to memory input port
- busy  out  1  high in LOAD and DONE
- done  out  1  one-cycle pulse after last write issued
- cfg_err  out  1  one-cycle pulse on rejected start

## Operation
- States: IDLE, LOAD, DONE.
- IDLE: s_ready=0. On start, validate config. Invalid (cfg_groups 0 or >Tn; full mode with cfg_lines 0 or >KERNEL_SIZE; single mode with cfg_line_sel ≥ KERNEL_SIZE) → cfg_err pulse next cycle, remain IDLE. Valid → latch all cfg_*, clear grp_cnt/line_cnt, go LOAD.
- LOAD: s_ready=1. Each handshake (s_valid & s_ready) writes one word:
  - full mode: target (grp_cnt, line_cnt); line_cnt increments, wraps to 0 at cfg_lines-1 while grp_cnt increments.
  - single mode: target (grp_cnt, cfg_line_sel); grp_cnt increments per beat.
  - handshake targeting last position (grp_cnt=cfg_groups-1 and, in full mode, line_cnt=cfg_lines-1) → DONE.
- s_valid low in LOAD: no write, counters hold; no timeout.
- DONE: s_ready=0, done=1 for exactly this cycle, then IDLE. start in LOAD/DONE is ignored (no cfg_err).
- Config inputs changing after latch have no effect on the current load.
- Total beats per load: cfg_groups×cfg_lines (full) or cfg_groups (single).

## Timing
- Reset: state IDLE, counters 0, s_ready=0, wr_en=0, wr_mem_group=0, wr_mem_line=0, wr_data=0, busy=0, done=0, cfg_err=0.
- start at cycle T (valid) → LOAD and s_ready=1 at T+1.
- Write port is registered: handshake at cycle N → wr_en=1 with group/line/data at N+1. No handshake at N → wr_en=0 and wr_mem_group, wr_mem_line, wr_data = 0 at N+1.
- Last handshake at N → state DONE, done=1, busy=1, last wr_en=1 all at N+1; IDLE, busy=0 at N+2. A new start is accepted at N+2 at the earliest.
- Back-to-back: one word per cycle sustained with s_valid held high.
- s_ready is a pure function of state (no combinational path from s_valid).
- rst mid-load: returns to reset values next cycle; partial load discarded, no done; pending write of the rst cycle is dropped (wr_en=0).

## Test plan
- Full load Tn=4, K=3, cfg_groups=4, cfg_lines=3, continuous s_valid, data=beat index 0..11 -> 12 writes (g,l) = (0,0),(0,1),(0,2),(1,0)…(3,2), wr_data matches index, done exactly one cycle after beat 11's handshake, s_ready low during DONE.
- Single mode cfg_groups=4, cfg_line_sel=2 -> 4 writes to (0,2),(1,2),(2,2),(3,2), then done; fifth offered word not accepted.
- Backpressure: s_valid toggling 1,0,0,1,… with cfg_groups=2, cfg_lines=2 -> wr_en only the cycle after each handshake, counters hold during gaps, 4 writes total.
- Invalid config: start with cfg_groups=0, then cfg_lines=4 (K=3), then single with cfg_line_sel=3 -> cfg_err pulse each, state stays IDLE, no wr_en.
- Reset mid-load after 5 of 12 beats -> all outputs 0 next cycle, no done; subsequent valid start restarts at (0,0).
- start asserted during LOAD with different config -> ignored, original load completes with original geometry.
